// File: rtl/button_repeat.sv
// -----------------------------------------------------------------------------
// button_repeat
// Two-channel push-button conditioner for increment/decrement keys.
// Each raw active-low key is synchronised, debounced and turned into fixed-width
// active-low pulses: one pulse on press, then auto-repeat while the key is held.
// Holding both keys at once engages an interlock under which neither channel
// fires until both keys have been released.
//
// Ports:
//   i_CLK      system clock
//   i_RST      asynchronous active-low reset
//   i_btn_inc  raw increment key, active-low, asynchronous to i_CLK
//   i_btn_dec  raw decrement key, active-low, asynchronous to i_CLK
//   o_inc_btn  conditioned increment pulse, active-low, idle high (registered)
//   o_dec_btn  conditioned decrement pulse, active-low, idle high (registered)
//   o_lock     high while the both-pressed interlock is active (registered)
//
// Channel index 0 is the increment key, index 1 the decrement key.
// -----------------------------------------------------------------------------
module button_repeat #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned HOLD_CYC     = 25000000,
    parameter int unsigned REPEAT_CYC   = 5000000,
    parameter int unsigned PULSE_CYC    = 2
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_btn_inc,
    input  logic i_btn_dec,
    output logic o_inc_btn,
    output logic o_dec_btn,
    output logic o_lock
);

    localparam int unsigned TIMER_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TMR_W     = $clog2(TIMER_MAX + 1);
    localparam int unsigned PLS_W     = $clog2(PULSE_CYC + 1);

    localparam logic [DEB_W-1:0] DEB_LIMIT  = DEB_W'(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0] DEB_ZERO   = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(32'd1);
    localparam logic [TMR_W-1:0] TMR_HOLD   = TMR_W'(HOLD_CYC);
    localparam logic [TMR_W-1:0] TMR_REPEAT = TMR_W'(REPEAT_CYC);
    localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(32'd1);
    localparam logic [PLS_W-1:0] PLS_LOAD   = PLS_W'(PULSE_CYC);
    localparam logic [PLS_W-1:0] PLS_ZERO   = {PLS_W{1'b0}};
    localparam logic [PLS_W-1:0] PLS_ONE    = PLS_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       deb_r;
    logic [1:0]       deb_n_s;
    logic [DEB_W-1:0] deb_cnt_r   [2];
    logic [DEB_W-1:0] deb_cnt_n_s [2];
    state_t           state_r     [2];
    state_t           state_n_s   [2];
    logic [TMR_W-1:0] timer_r     [2];
    logic [TMR_W-1:0] timer_n_s   [2];
    logic [PLS_W-1:0] pls_cnt_r   [2];
    logic [PLS_W-1:0] pls_cnt_n_s [2];
    logic [1:0]       fire_s;
    logic             both_pressed_s;
    logic             both_released_s;
    logic [1:0]       btn_out_r;
    logic             lock_r;

    assign raw_s = {i_btn_dec, i_btn_inc};

    // Two-flop synchroniser for the raw keys; idles at released (1).
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count cycles of disagreement; adopt the new level once the count hits the limit.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            deb_n_s[ch]     = deb_r[ch];
            deb_cnt_n_s[ch] = DEB_ZERO;
            if (sync2_r[ch] == deb_r[ch]) begin
                deb_cnt_n_s[ch] = DEB_ZERO;
            end else if (deb_cnt_r[ch] == DEB_LIMIT) begin
                deb_n_s[ch]     = sync2_r[ch];
                deb_cnt_n_s[ch] = DEB_ZERO;
            end else begin
                deb_cnt_n_s[ch] = deb_cnt_r[ch] + DEB_ONE;
            end
        end
    end

    // Debounced levels and their stability counters.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            deb_r <= 2'b11;
            for (int ch = 0; ch < 2; ch++) begin
                deb_cnt_r[ch] <= DEB_ZERO;
            end
        end else begin
            deb_r <= deb_n_s;
            for (int ch = 0; ch < 2; ch++) begin
                deb_cnt_r[ch] <= deb_cnt_n_s[ch];
            end
        end
    end

    assign both_pressed_s  = (deb_r == 2'b00);
    assign both_released_s = (deb_r == 2'b11);

    // Per-channel press/hold/repeat FSM. The timer is loaded only when a pulse
    // fires, so a fire happens on the cycle the timer would step from 1 to 0.
    // Both-pressed forces every channel into LOCK, so the two FSMs always
    // enter and leave LOCK together.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_n_s[ch] = state_r[ch];
            timer_n_s[ch] = timer_r[ch];
            fire_s[ch]    = 1'b0;
            case (state_r[ch])
                ST_IDLE: begin
                    if (both_pressed_s) begin
                        state_n_s[ch] = ST_LOCK;
                    end else if (!deb_r[ch]) begin
                        fire_s[ch]    = 1'b1;
                        timer_n_s[ch] = TMR_HOLD;
                        state_n_s[ch] = ST_HOLD;
                    end else begin
                        state_n_s[ch] = ST_IDLE;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (both_pressed_s) begin
                        state_n_s[ch] = ST_LOCK;
                    end else if (deb_r[ch]) begin
                        state_n_s[ch] = ST_IDLE;
                    end else if (timer_r[ch] <= TMR_ONE) begin
                        fire_s[ch]    = 1'b1;
                        timer_n_s[ch] = TMR_REPEAT;
                        state_n_s[ch] = ST_REPEAT;
                    end else begin
                        timer_n_s[ch] = timer_r[ch] - TMR_ONE;
                    end
                end
                ST_LOCK: begin
                    if (both_released_s) begin
                        state_n_s[ch] = ST_IDLE;
                    end else begin
                        state_n_s[ch] = ST_LOCK;
                    end
                end
                default: begin
                    state_n_s[ch] = ST_IDLE;
                    timer_n_s[ch] = TMR_ZERO;
                end
            endcase
        end
    end

    // Pulse down-counter: a running pulse always completes; fires during it are dropped.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            pls_cnt_n_s[ch] = PLS_ZERO;
            if (pls_cnt_r[ch] != PLS_ZERO) begin
                pls_cnt_n_s[ch] = pls_cnt_r[ch] - PLS_ONE;
            end else if (fire_s[ch]) begin
                pls_cnt_n_s[ch] = PLS_LOAD;
            end else begin
                pls_cnt_n_s[ch] = PLS_ZERO;
            end
        end
    end

    // FSM state, timers, pulse counters and registered outputs.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch]   <= ST_IDLE;
                timer_r[ch]   <= TMR_ZERO;
                pls_cnt_r[ch] <= PLS_ZERO;
            end
            btn_out_r <= 2'b11;
            lock_r    <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch]   <= state_n_s[ch];
                timer_r[ch]   <= timer_n_s[ch];
                pls_cnt_r[ch] <= pls_cnt_n_s[ch];
                btn_out_r[ch] <= (pls_cnt_n_s[ch] == PLS_ZERO);
            end
            lock_r <= (state_n_s[0] == ST_LOCK) || (state_n_s[1] == ST_LOCK);
        end
    end

    assign o_inc_btn = btn_out_r[0];
    assign o_dec_btn = btn_out_r[1];
    assign o_lock    = lock_r;

endmodule

// File: tb/tb_button_repeat.sv
// -----------------------------------------------------------------------------
// tb_button_repeat
// Self-checking bench for button_repeat with DEBOUNCE_CYC=4, HOLD_CYC=20,
// REPEAT_CYC=8, PULSE_CYC=2. Expected pulse-start edges are queued when the
// stimulus is applied; a monitor pops and compares them as falling edges of
// the outputs appear, and checks every pulse width.
// Edge numbering: an input driven at a negedge is first sampled at relative
// edge 0 of the scenario.
// -----------------------------------------------------------------------------
module tb_button_repeat;

    localparam int DEB = 4;
    localparam int HLD = 20;
    localparam int RPT = 8;
    localparam int PLS = 2;
    localparam int LAT = DEB + 3;

    logic clk_s     = 1'b0;
    logic rst_s     = 1'b0;
    logic btn_inc_s = 1'b1;
    logic btn_dec_s = 1'b1;
    logic inc_out_s;
    logic dec_out_s;
    logic lock_s;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int edge_no   = 0;
    int base      = 0;

    int q_inc[$];
    int q_dec[$];
    logic prev_inc = 1'b1;
    logic prev_dec = 1'b1;
    int   inc_start = 0;
    int   dec_start = 0;

    button_repeat #(
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HLD),
        .REPEAT_CYC  (RPT),
        .PULSE_CYC   (PLS)
    ) dut (
        .i_CLK    (clk_s),
        .i_RST    (rst_s),
        .i_btn_inc(btn_inc_s),
        .i_btn_dec(btn_dec_s),
        .o_inc_btn(inc_out_s),
        .o_dec_btn(dec_out_s),
        .o_lock   (lock_s)
    );

    // Free-running clock.
    always #5 clk_s = ~clk_s;

    // Absolute edge counter used to time-stamp pulses.
    always @(posedge clk_s) edge_no <= edge_no + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: compares each pulse start with the scoreboard and checks its width.
    always @(posedge clk_s) begin
        #1;
        if (!rst_s) begin
            prev_inc = 1'b1;
            prev_dec = 1'b1;
        end else begin
            if (prev_inc && !inc_out_s) begin
                if (q_inc.size() == 0) check_eq("inc_unexpected", edge_no, -1);
                else                   check_eq("inc_start", edge_no, q_inc.pop_front());
                inc_start = edge_no;
            end
            if (!prev_inc && inc_out_s) check_eq("inc_width", edge_no - inc_start, PLS);
            if (prev_dec && !dec_out_s) begin
                if (q_dec.size() == 0) check_eq("dec_unexpected", edge_no, -1);
                else                   check_eq("dec_start", edge_no, q_dec.pop_front());
                dec_start = edge_no;
            end
            if (!prev_dec && dec_out_s) check_eq("dec_width", edge_no - dec_start, PLS);
            prev_inc = inc_out_s;
            prev_dec = dec_out_s;
        end
    end

    // Absolute edge number of scenario-relative edge rel.
    function automatic int ed(input int rel);
        return base + 1 + rel;
    endfunction

    task automatic start_scn();
        @(negedge clk_s);
        base = edge_no;
    endtask

    // Return at the negedge just before relative edge k samples the inputs.
    task automatic at_edge(input int k);
        while (edge_no < base + k) @(negedge clk_s);
    endtask

    task automatic end_scn(input string tag);
        check_eq({tag, "_pending"}, q_inc.size() + q_dec.size(), 0);
        q_inc.delete();
        q_dec.delete();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_s);
        check_eq("rst_inc", inc_out_s, 1);
        check_eq("rst_dec", dec_out_s, 1);
        check_eq("rst_lock", lock_s, 0);
        rst_s = 1'b1;
        repeat (3) @(negedge clk_s);

        // 1: single tap.
        start_scn();
        q_inc.push_back(ed(LAT));
        btn_inc_s = 1'b0;
        at_edge(10); btn_inc_s = 1'b1;
        at_edge(30);
        check_eq("s1_lock", lock_s, 0);
        check_eq("s1_dec", dec_out_s, 1);
        end_scn("s1");

        // 2: bounce on dec, then a stable press.
        start_scn();
        for (int i = 0; i < 10; i++) begin
            at_edge(2 * i);
            btn_dec_s = (i % 2 == 1) ? 1'b1 : 1'b0;
        end
        at_edge(30);
        q_dec.push_back(ed(30 + LAT));
        btn_dec_s = 1'b0;
        at_edge(40); btn_dec_s = 1'b1;
        at_edge(60);
        end_scn("s2");

        // 3: hold with auto-repeat.
        start_scn();
        q_inc.push_back(ed(LAT));
        for (int k = 0; k < 5; k++) q_inc.push_back(ed(LAT + HLD + k * RPT));
        btn_inc_s = 1'b0;
        at_edge(60); btn_inc_s = 1'b1;
        at_edge(90);
        check_eq("s3_lock", lock_s, 0);
        end_scn("s3");

        // 4: interlock after an inc press.
        start_scn();
        q_inc.push_back(ed(LAT));
        btn_inc_s = 1'b0;
        at_edge(10); btn_dec_s = 1'b0;
        at_edge(17); check_eq("s4_lock_pre", lock_s, 0);
        at_edge(18); check_eq("s4_lock_on", lock_s, 1);
        at_edge(35); check_eq("s4_lock_hold", lock_s, 1);
        at_edge(40); btn_inc_s = 1'b1; btn_dec_s = 1'b1;
        at_edge(50); check_eq("s4_lock_off", lock_s, 0);
        q_inc.push_back(ed(50 + LAT));
        btn_inc_s = 1'b0;
        at_edge(55); btn_inc_s = 1'b1;
        at_edge(80);
        end_scn("s4");

        // 5: simultaneous press.
        start_scn();
        btn_inc_s = 1'b0; btn_dec_s = 1'b0;
        at_edge(7);  check_eq("s5_lock_pre", lock_s, 0);
        at_edge(8);  check_eq("s5_lock_on", lock_s, 1);
        at_edge(40); check_eq("s5_lock_hold", lock_s, 1);
        btn_inc_s = 1'b1; btn_dec_s = 1'b1;
        at_edge(55); check_eq("s5_lock_off", lock_s, 0);
        end_scn("s5");

        // 6: reset in the middle of a pulse, key held through it.
        start_scn();
        q_inc.push_back(ed(LAT));
        btn_inc_s = 1'b0;
        at_edge(LAT + 1);
        check_eq("s6_pulse_low", inc_out_s, 0);
        #2 rst_s = 1'b0;
        #1 check_eq("s6_async_high", inc_out_s, 1);
        check_eq("s6_lock", lock_s, 0);
        @(negedge clk_s);
        @(negedge clk_s);
        rst_s = 1'b1;
        base = edge_no;
        q_inc.push_back(ed(LAT));
        at_edge(12); btn_inc_s = 1'b1;
        at_edge(40);
        end_scn("s6");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
